fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter placed in front of `fifo_controller`. It shares the single FIFO write port between N requesters and grants in bursts of up to MAX_BURST words. It converts the FIFO full flag into per-requester backpressure, so no write is ever issued while the FIFO is full. Data from the granted requester is muxed onto the FIFO write data path.

## Interface
- N, 4, number of requesters (N >= 2)
- W, 8, data width in bits
- MAX_BURST, 4, maximum words per grant (>= 1)

- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_req  input  N  per-requester write request; bit k held high while requester k has data
- i_last  input  N  per-requester last-word marker, qualified by the transfer
- i_data  input  N*W  requester data; requester k at bits [k*W +: W]
- i_full  input  1  FIFO full flag from fifo_controller `o_full`
- o_gnt  output  N  one-hot transfer strobe; bit k high means requester k's word is taken this cycle
- o_wr  output  1  FIFO write strobe to fifo_controller `i_wr`
- o_wdata  output  W  FIFO write data
- o_owner  output  $clog2(N)  index of the current burst owner; valid while o_busy
- o_busy  output  1  high while in BURST

## Operation
- Registered state: `state` (IDLE/BURST), `owner`, `last_win` ($clog2(N)), `cnt` ($clog2(MAX_BURST+1) bits).
- IDLE:
  - o_gnt = 0 and o_wr = 0.
  - If any i_req bit is set, select the first set bit scanning last_win+1, last_win+2, … with wrap modulo N.
  - Latch the selected index into owner, clear cnt, and go to BURST.
  - If no i_req bit is set, stay in IDLE.
- BURST, combinational outputs:
  - xfer = i_req[owner] && !i_full.
  - o_wr = xfer.
  - o_gnt = xfer ? (1 << owner) : 0.
  - o_wdata = i_data[owner].
- BURST, per cycle:
  - On xfer, cnt increments.
  - Exit to IDLE, setting last_win = owner, when any of these holds:
    - xfer && i_last[owner];
    - xfer && cnt+1 == MAX_BURST;
    - !i_req[owner] (requester withdrew; no transfer that cycle).
  - Otherwise stay in BURST.
- i_full in BURST: xfer = 0 and cnt holds. The stall has no timeout, and the burst resumes when i_full falls.
- Non-owner requesters see o_gnt = 0 and must hold i_req and i_data.
- Invariants:
  - o_wr && i_full is never true.
  - o_gnt is zero or one-hot.
  - o_wr == |o_gnt.
- o_wdata outside BURST: i_data[owner] (don't-care, not checked).

## Timing
- Reset, on i_rst high at a rising edge:
  - state = IDLE, owner = 0, cnt = 0.
  - last_win = N-1, so requester 0 has first priority.
  - o_gnt = 0, o_wr = 0, o_busy = 0, o_owner = 0.
- Reset mid-burst: the burst is abandoned with no further o_wr. A word transferred in the reset cycle is not counted.
- Arbitration latency: i_req seen at edge t in IDLE → BURST from t+1, with the first possible o_wr in cycle t+1.
- Each exit from BURST costs exactly one IDLE cycle.
- Peak throughput with i_full low: MAX_BURST words per MAX_BURST+1 cycles.
- Fairness: a continuously requesting requester waits at most (N-1) bursts, excluding stall cycles.
- Simultaneous requests: resolved purely by round-robin order from last_win; requester index has no other priority.
- i_last on a word that also reaches MAX_BURST: a single exit; both conditions have the same effect.
- The block never reads o_empty or the FIFO pointers; FIFO wrap-around is fifo_controller's responsibility.

## Test plan
- Reset, then i_req=4'b1111, i_last=0, MAX_BURST=4, i_full=0 →
  - one IDLE cycle, then owner 0 gets 4 consecutive o_wr;
  - IDLE, then owner 1, then 2, then 3, then 0 again.
- i_req=4'b0100 only, i_last[2] asserted on the 2nd transfer → exactly 2 o_wr with o_owner=2, then IDLE; last_win=2.
- Owner 1 mid-burst after 1 word, i_full high for 3 cycles →
  - o_wr=0 and o_gnt=0 for those 3 cycles, cnt stays 1;
  - after i_full drops, 3 more words, then exit.
- Owner 3 drops i_req after 2 words with i_req[0] high → BURST exits with no further o_wr; next owner is 0 (wrap from 3).
- i_rst pulsed during the 3rd word of a burst by owner 2 → next cycle o_busy=0, o_wr=0; first grant after reset goes to requester 0.
- Random i_req, i_last, i_full for 10k cycles → checker asserts:
  - !(o_wr && i_full);
  - o_gnt is zero or one-hot and o_wr == |o_gnt;
  - no burst exceeds MAX_BURST;
  - round-robin fairness bound.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of fifo_controller.
// Shares one FIFO write port between N requesters, granting bursts of up to
// MAX_BURST words, and turns the FIFO full flag into per-requester backpressure.
module fifo_wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_last,
  input  logic [N*W-1:0]       i_data,
  input  logic                 i_full,
  output logic [N-1:0]         o_gnt,
  output logic                 o_wr,
  output logic [W-1:0]         o_wdata,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_busy
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  logic          state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_win_q, last_win_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [OW-1:0] sel;
  logic [OW-1:0] rr_idx;
  logic          any_req;
  logic          own_req;
  logic          own_last;
  logic          xfer;
  logic [CW-1:0] cnt_inc;
  logic          burst_end;

  assign any_req = |i_req;
  assign own_req  = i_req[owner_q];
  assign own_last = i_last[owner_q];
  assign xfer     = (state_q == ST_BURST) && own_req && !i_full;
  assign cnt_inc  = cnt_q + CW'(1);

  // Withdrawal ends the burst without a transfer; last word or a full burst ends it after one.
  assign burst_end = !own_req || (xfer && (own_last || (cnt_inc == CW'(MAX_BURST))));

  // Round-robin pick: scan from the largest offset down so the nearest requester after
  // last_win is the final (winning) assignment.
  always_comb begin
    sel    = '0;
    rr_idx = '0;
    for (int off = int'(N); off >= 1; off--) begin
      rr_idx = OW'((32'(last_win_q) + 32'(off)) % N);
      if (i_req[rr_idx]) sel = rr_idx;
    end
  end

  // Next-state for the IDLE/BURST controller and its bookkeeping registers.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_win_d = last_win_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BURST;
          owner_d = sel;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (xfer) cnt_d = cnt_inc;
        if (burst_end) begin
          state_d    = ST_IDLE;
          last_win_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; last_win starts at N-1 so requester 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_win_q <= OW'(N - 1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_win_q <= last_win_d;
      cnt_q      <= cnt_d;
    end
  end

  // Grant strobe and write-data mux follow the current owner.
  always_comb begin
    o_gnt   = '0;
    o_wdata = i_data[W-1:0];
    for (int k = 0; k < int'(N); k++) begin
      if (owner_q == OW'(k)) begin
        o_gnt[k] = xfer;
        o_wdata  = i_data[k*W +: W];
      end
    end
  end

  assign o_wr    = xfer;
  assign o_owner = owner_q;
  assign o_busy  = (state_q == ST_BURST);

endmodule
